// File: rtl/mul_pkg.sv
// Shared types and helpers for the Booth / Wallace multiplier pipeline.
// Op encoding, Booth digit encoding, and CSA tree sizing functions.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_dig_t;

    function automatic booth_dig_t booth_sel(input logic [2:0] win);
        booth_dig_t d;
        unique case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

    // Rows left after lvl levels of 3:2 compression starting from r0 rows.
    function automatic int csa_rows(input int r0, input int lvl);
        int n;
        n = r0;
        for (int i = 0; i < lvl; i++) n = n - n / 3;
        return n;
    endfunction

    function automatic int csa_levels(input int r0);
        int n;
        int l;
        n = r0;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product from the extended multiplicand.
// Negative digits return ~X; the +1 is reported on neg for the tree.
module booth_pp_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN+1:0] ax,
    input  logic [2:0]      win,
    output logic [XLEN+2:0] pp,
    output logic            neg
);
    import mul_pkg::*;

    booth_dig_t      dig;
    logic [XLEN+2:0] a1;
    logic [XLEN+2:0] a2;

    assign dig = booth_sel(win);
    assign a1  = {ax[XLEN+1], ax};
    assign a2  = {ax, 1'b0};

    always_comb begin
        pp  = '0;
        neg = 1'b0;
        unique case (dig)
            POS1: pp = a1;
            POS2: pp = a2;
            NEG1: begin
                pp  = ~a1;
                neg = 1'b1;
            end
            NEG2: begin
                pp  = ~a2;
                neg = 1'b1;
            end
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth / Wallace multiplier (MUL/MULH/MULHSU/MULHU).
// Define MUL_FLUSH_EN to add the flush input that kills in-flight ops.
module booth_mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
`ifdef MUL_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    output logic [XLEN-1:0]  out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    import mul_pkg::*;

    localparam int P   = 2 * XLEN;
    localparam int NPP = XLEN / 2 + 1;
    localparam int R   = NPP + 1;
    localparam int NL  = csa_levels(R);
    localparam int NC  = (STAGES > 1) ? STAGES - 1 : 1;

    mul_op_t         op_in;
    logic            a_sx;
    logic            b_sx;
    logic [XLEN+1:0] ax;
    logic [XLEN+1:0] bx;
    logic [XLEN+2:0] pp [NPP];
    logic [NPP-1:0]  neg;
    logic [P-1:0]    hot;
    logic            kill;

    logic [P-1:0]    st_in  [NC][R];
    logic [P-1:0]    st_out [NC][R];

    logic [NC-1:0]   pv;
    mul_op_t         pop  [NC];
    logic [TAG_W-1:0] ptag [NC];
    logic [P-1:0]    prow [NC][R];

    logic            l_v;
    mul_op_t         l_op;
    logic [TAG_W-1:0] l_tag;
    logic [P-1:0]    l_s;
    logic [P-1:0]    l_c;
    logic [P-1:0]    prod;
    logic [XLEN-1:0] res;

`ifdef MUL_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign op_in = mul_op_t'(in_op);
    assign a_sx  = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign b_sx  = (op_in == OP_MULH);
    assign ax    = {{2{a_sx & in_a[XLEN-1]}}, in_a};
    assign bx    = {{2{b_sx & in_b[XLEN-1]}}, in_b};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [2:0] win;
        if (i == 0) begin : g_w0
            assign win = {bx[1:0], 1'b0};
        end else begin : g_wn
            assign win = bx[2*i+1:2*i-1];
        end
        booth_pp_gen #(.XLEN(XLEN)) u_pp (
            .ax  (ax),
            .win (win),
            .pp  (pp[i]),
            .neg (neg[i])
        );
        assign st_in[0][i] = {{(P-XLEN-3){pp[i][XLEN+2]}}, pp[i]} << (2 * i);
    end

    // The +1 of every negated row is collected into one extra tree row.
    always_comb begin
        hot = '0;
        for (int i = 0; i < NPP; i++) hot[2*i] = neg[i];
    end
    assign st_in[0][NPP] = hot;

    for (genvar k = 0; k < NC; k++) begin : g_st
        localparam int L0  = k * NL / NC;
        localparam int L1  = (k + 1) * NL / NC;
        localparam int NLV = L1 - L0;

        logic [P-1:0] sl [0:NLV][0:R-1];

        if (k > 0) begin : g_in
            assign st_in[k] = prow[k-1];
        end
        assign sl[0] = st_in[k];

        for (genvar l = 0; l < NLV; l++) begin : g_lv
            localparam int N  = csa_rows(R, L0 + l);
            localparam int N3 = N / 3;
            localparam int NN = csa_rows(R, L0 + l + 1);
            for (genvar r = 0; r < R; r++) begin : g_r
                if (r < 2 * N3) begin : g_csa
                    localparam int J = r / 2;
                    if (r % 2 == 0) begin : g_s
                        assign sl[l+1][r] = sl[l][3*J] ^ sl[l][3*J+1]
                                          ^ sl[l][3*J+2];
                    end else begin : g_c
                        assign sl[l+1][r] =
                            ((sl[l][3*J]   & sl[l][3*J+1])
                           | (sl[l][3*J]   & sl[l][3*J+2])
                           | (sl[l][3*J+1] & sl[l][3*J+2])) << 1;
                    end
                end else if (r < NN) begin : g_pass
                    assign sl[l+1][r] = sl[l][r+N3];
                end else begin : g_idle
                    assign sl[l+1][r] = sl[l][r];
                end
            end
        end

        assign st_out[k] = sl[NLV];
    end

    if (STAGES > 1) begin : g_last_reg
        assign l_v   = pv[NC-1];
        assign l_op  = pop[NC-1];
        assign l_tag = ptag[NC-1];
        assign l_s   = prow[NC-1][0];
        assign l_c   = prow[NC-1][1];
        assign busy  = (|pv) | out_valid;
    end else begin : g_last_comb
        assign l_v   = in_valid;
        assign l_op  = op_in;
        assign l_tag = in_tag;
        assign l_s   = st_out[0][0];
        assign l_c   = st_out[0][1];
        assign busy  = out_valid;
    end

    assign prod = l_s + l_c;
    assign res  = (l_op == OP_MUL) ? prod[XLEN-1:0] : prod[P-1:XLEN];

    // Output data only reloads on a valid op so it holds across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv        <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            for (int k = 0; k < NC; k++) begin
                pop[k]  <= OP_MUL;
                ptag[k] <= '0;
                for (int r = 0; r < R; r++) prow[k][r] <= '0;
            end
        end else if (kill) begin
            pv        <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            pv[0]   <= in_valid;
            pop[0]  <= op_in;
            ptag[0] <= in_tag;
            prow[0] <= st_out[0];
            for (int k = 1; k < NC; k++) begin
                pv[k]   <= pv[k-1];
                pop[k]  <= pop[k-1];
                ptag[k] <= ptag[k-1];
                prow[k] <= st_out[k];
            end
            out_valid <= l_v;
            if (l_v) begin
                out_p   <= res;
                out_tag <= l_tag;
            end
        end
    end

endmodule
